lsf_hist_seq: RTL and testbench
===============================

Name: lsf_hist_seq

Overview:
- Event sequencer that sits directly around the LSF r-bin histogram (update_histogram_reg).
- Accepts the per-event stream of r-bin pairs, forwards it registered to the histogram, and drives enable_V and reset_rbins.
- Tracks the running maximum from the histogram's local_max_* stream, waits for the histogram pipeline to drain after the last hit, then presents one result per event on a valid/ready interface.
- Clears the histogram after the result is consumed.

Parameters:
- RBIN_WIDTH, 8, r-bin width including sign bit (MSB=1 means invalid bin).
- MAX_HITS, 32, maximum beats forwarded per event; excess beats are consumed and dropped.
- DRAIN_CYCLES, 5, cycles spent in DRAIN after the last forwarded beat; must be >=4 (1 cycle output register + 3 cycles histogram latency).
- MIN_COUNT, 3, minimum peak count for res_found.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_r_bin_0  in  RBIN_WIDTH  hit r-bin, tube 0
- in_r_bin_1  in  RBIN_WIDTH  hit r-bin, tube 1
- in_vld  in  1  beat valid
- in_last  in  1  last beat of event
- in_ready  out  1  beat accepted when in_vld&in_ready
- flush  in  1  synchronous abort of the current event
- r_bin_0, r_bin_1  out  RBIN_WIDTH  to histogram
- r_bin_vld  out  1  to histogram
- enable_V  out  1  to histogram
- reset_rbins  out  1  to histogram
- local_max_rbin  in  RBIN_WIDTH-1  from histogram
- local_max_count  in  4  from histogram
- local_max_vld  in  1  from histogram
- res_rbin  out  RBIN_WIDTH-1  peak bin
- res_count  out  4  peak count
- res_nhits  out  $clog2(MAX_HITS+1)  beats forwarded
- res_found  out  1  res_count>=MIN_COUNT
- res_overflow  out  1  beats were dropped
- res_vld  out  1  result valid
- res_ready  in  1  result consumed when res_vld&res_ready

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous active-low.
- Reset: rst_n low immediately forces state IDLE and every output to 0, except enable_V=1 and in_ready=1 after reset release. best_rbin, best_count, nhits, overflow and drain counter are cleared.
- States: IDLE, ACCUM, DRAIN, OUTPUT, CLEAR.
- IDLE and ACCUM:
  - in_ready=1, enable_V=1.
  - Accepted beat: if nhits<MAX_HITS, register it onto r_bin_*/r_bin_vld next cycle (latency 1) and increment nhits. Otherwise drop it and set overflow.
  - r_bin_vld=0 in cycles with no forwarded beat.
  - Accepted beat with in_last=0 -> ACCUM. With in_last=1 -> DRAIN, counter loaded with DRAIN_CYCLES.
  - A single-beat event goes IDLE->DRAIN.
- DRAIN:
  - in_ready=0, enable_V=1.
  - Counter decrements each cycle; at 1 -> OUTPUT.
- Max capture:
  - Any cycle in ACCUM or DRAIN with local_max_vld=1: best_rbin<=local_max_rbin, best_count<=local_max_count.
  - The histogram emits only strictly increasing maxima, so the latest value is the best.
  - Sign-bit beats are forwarded unchanged; the histogram ignores them.
- OUTPUT:
  - in_ready=0, enable_V=0.
  - res_vld=1. All res_* fields are driven from the registered best/nhits/overflow and stay stable until res_ready.
  - On handshake -> CLEAR.
- CLEAR:
  - reset_rbins=1 for exactly one cycle, enable_V=0, in_ready=0.
  - best, nhits and overflow are cleared, then -> IDLE.
- Event with no valid bins: res_count=0, res_rbin=0, res_found=0.
- flush=1 in ACCUM, DRAIN or OUTPUT -> CLEAR next cycle; no result is emitted and res_vld drops.
  - flush in IDLE is ignored.
  - flush has priority over a simultaneous beat or res handshake; that beat is not forwarded.
- Simultaneous in_last and nhits==MAX_HITS: the beat is dropped, overflow=1, and the block still goes to DRAIN.
- nhits saturates at MAX_HITS; there is no wrap.

Decomposition:
- Shared package lsf_hist_pkg holds:
  - state enum lsf_hist_state_t;
  - constant LSF_HIST_CNT_W=4;
  - constant LSF_HIST_LAT=3 (histogram r_bin_vld->local_max_vld latency);
  - packed struct lsf_hist_res_t {rbin, count, nhits, found, overflow}.
- Single module; no sub-module is natural.

Test Plan:
- Beats (5,9), (5,12), (5,0x83 last), MIN_COUNT=3 -> one res_vld with res_rbin=5, res_count=3, res_nhits=3, res_found=1, res_overflow=0; then a one-cycle reset_rbins.
- Beats (0x85,0x89), (0x80,0x81 last) -> res_count=0, res_rbin=0, res_found=0, res_nhits=2.
- res_ready held low 10 cycles in OUTPUT -> res_* stable and in_ready=0 throughout, no reset_rbins. res_ready=1 -> reset_rbins pulses one cycle, and in_ready=1 the following cycle.
- MAX_HITS=4, 6 beats with the last flagged -> exactly 4 r_bin_vld pulses, res_nhits=4, res_overflow=1.
- flush asserted 2 cycles into DRAIN -> no res_vld, one-cycle reset_rbins, IDLE. A following event yields correct counts with no carry-over.
- rst_n pulled low mid-ACCUM (asynchronous, between edges) -> r_bin_vld, res_vld and reset_rbins go 0 immediately. After release, a fresh event (7,7 last) yields res_rbin=7, res_count=1.

Source files
------------

// File: rtl/lsf_hist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsf_hist_pkg
//  Description : Shared types and constants for the LSF r-bin histogram
//                event sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsf_hist_pkg;

    localparam int LSF_HIST_CNT_W   = 4;
    localparam int LSF_HIST_LAT     = 3;
    localparam int LSF_HIST_RBIN_W  = 7;
    localparam int LSF_HIST_NHITS_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCUM  = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_CLEAR  = 3'd4
    } lsf_hist_state_t;

    typedef struct packed {
        logic [LSF_HIST_RBIN_W-1:0]  rbin;
        logic [LSF_HIST_CNT_W-1:0]   count;
        logic [LSF_HIST_NHITS_W-1:0] nhits;
        logic                        found;
        logic                        overflow;
    } lsf_hist_res_t;

endpackage
`default_nettype wire

// File: rtl/lsf_hist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : lsf_hist_seq
//  Description : Per-event sequencer around the LSF r-bin histogram: forwards
//                hits, tracks the running peak, drains, reports, clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsf_hist_seq
    import lsf_hist_pkg::*;
#(
    parameter int RBIN_WIDTH   = 8,
    parameter int MAX_HITS     = 32,
    parameter int DRAIN_CYCLES = 5,
    parameter int MIN_COUNT    = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [RBIN_WIDTH-1:0]           in_r_bin_0,
    input  logic [RBIN_WIDTH-1:0]           in_r_bin_1,
    input  logic                            in_vld,
    input  logic                            in_last,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [RBIN_WIDTH-1:0]           r_bin_0,
    output logic [RBIN_WIDTH-1:0]           r_bin_1,
    output logic                            r_bin_vld,
    output logic                            enable_V,
    output logic                            reset_rbins,
    input  logic [RBIN_WIDTH-2:0]           local_max_rbin,
    input  logic [LSF_HIST_CNT_W-1:0]       local_max_count,
    input  logic                            local_max_vld,
    output logic [RBIN_WIDTH-2:0]           res_rbin,
    output logic [LSF_HIST_CNT_W-1:0]       res_count,
    output logic [$clog2(MAX_HITS+1)-1:0]   res_nhits,
    output logic                            res_found,
    output logic                            res_overflow,
    output logic                            res_vld,
    input  logic                            res_ready
);

    localparam int NHITS_W = $clog2(MAX_HITS+1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES+1);

    localparam logic [NHITS_W-1:0]        c_max_hits   = NHITS_W'(MAX_HITS);
    localparam logic [LSF_HIST_CNT_W-1:0] c_min_count  = LSF_HIST_CNT_W'(MIN_COUNT);
    localparam logic [DRAIN_W-1:0]        c_drain_load = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0]        c_drain_one  = DRAIN_W'(1);

    lsf_hist_state_t             r_state;
    lsf_hist_state_t             w_state_nxt;
    logic [DRAIN_W-1:0]          r_drain_cnt;
    logic [NHITS_W-1:0]          r_nhits;
    logic                        r_overflow;
    logic [RBIN_WIDTH-2:0]       r_best_rbin;
    logic [LSF_HIST_CNT_W-1:0]   r_best_count;

    logic w_accept;
    logic w_flush;
    logic w_take;
    logic w_fwd;
    logic w_drop;
    logic w_capture;

    assign w_accept  = in_vld & in_ready;
    assign w_flush   = flush & ((r_state == ST_ACCUM) | (r_state == ST_DRAIN) |
                                (r_state == ST_OUTPUT));
    // A flushed beat is handshaken but neither forwarded nor counted.
    assign w_take    = w_accept & ~w_flush;
    assign w_fwd     = w_take & (r_nhits < c_max_hits);
    assign w_drop    = w_take & ~(r_nhits < c_max_hits);
    assign w_capture = local_max_vld & ((r_state == ST_ACCUM) | (r_state == ST_DRAIN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = in_last ? ST_DRAIN : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (w_flush)       w_state_nxt = ST_CLEAR;
                else if (w_accept) w_state_nxt = in_last ? ST_DRAIN : ST_ACCUM;
            end
            ST_DRAIN: begin
                if (w_flush)                         w_state_nxt = ST_CLEAR;
                else if (r_drain_cnt == c_drain_one) w_state_nxt = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (w_flush || res_ready) w_state_nxt = ST_CLEAR;
            end
            ST_CLEAR:  w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        enable_V    = 1'b0;
        reset_rbins = 1'b0;
        res_vld     = 1'b0;
        case (r_state)
            ST_IDLE, ST_ACCUM: begin
                in_ready = 1'b1;
                enable_V = 1'b1;
            end
            ST_DRAIN:  enable_V    = 1'b1;
            ST_OUTPUT: res_vld     = 1'b1;
            ST_CLEAR:  reset_rbins = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin_0      <= '0;
            r_bin_1      <= '0;
            r_bin_vld    <= 1'b0;
            r_drain_cnt  <= '0;
            r_nhits      <= '0;
            r_overflow   <= 1'b0;
            r_best_rbin  <= '0;
            r_best_count <= '0;
        end else begin
            r_bin_vld <= w_fwd;
            if (w_fwd) begin
                r_bin_0 <= in_r_bin_0;
                r_bin_1 <= in_r_bin_1;
            end

            if (w_take && in_last) begin
                r_drain_cnt <= c_drain_load;
            end else if (r_state == ST_DRAIN && r_drain_cnt != '0) begin
                r_drain_cnt <= r_drain_cnt - c_drain_one;
            end

            if (r_state == ST_CLEAR) begin
                r_nhits      <= '0;
                r_overflow   <= 1'b0;
                r_best_rbin  <= '0;
                r_best_count <= '0;
            end else begin
                if (w_fwd)  r_nhits    <= r_nhits + NHITS_W'(1);
                if (w_drop) r_overflow <= 1'b1;
                // Histogram maxima arrive strictly increasing, so the latest wins.
                if (w_capture) begin
                    r_best_rbin  <= local_max_rbin;
                    r_best_count <= local_max_count;
                end
            end
        end
    end

    assign res_rbin     = r_best_rbin;
    assign res_count    = r_best_count;
    assign res_nhits    = r_nhits;
    assign res_found    = (r_best_count >= c_min_count);
    assign res_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_lsf_hist_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsf_hist_seq
//  Description : Directed self-checking bench for lsf_hist_seq with a small
//                behavioural model of the r-bin histogram.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsf_hist_seq;
    import lsf_hist_pkg::*;

    localparam int RW = 8;
    localparam int MH = 4;
    localparam int DC = 5;
    localparam int MC = 3;
    localparam int NW = $clog2(MH+1);

    logic                       clk;
    logic                       rst_n;
    logic [RW-1:0]              in_r_bin_0;
    logic [RW-1:0]              in_r_bin_1;
    logic                       in_vld;
    logic                       in_last;
    logic                       in_ready;
    logic                       flush;
    logic [RW-1:0]              r_bin_0;
    logic [RW-1:0]              r_bin_1;
    logic                       r_bin_vld;
    logic                       enable_V;
    logic                       reset_rbins;
    logic [RW-2:0]              local_max_rbin;
    logic [LSF_HIST_CNT_W-1:0]  local_max_count;
    logic                       local_max_vld;
    logic [RW-2:0]              res_rbin;
    logic [LSF_HIST_CNT_W-1:0]  res_count;
    logic [NW-1:0]              res_nhits;
    logic                       res_found;
    logic                       res_overflow;
    logic                       res_vld;
    logic                       res_ready;

    lsf_hist_seq #(
        .RBIN_WIDTH   (RW),
        .MAX_HITS     (MH),
        .DRAIN_CYCLES (DC),
        .MIN_COUNT    (MC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_r_bin_0      (in_r_bin_0),
        .in_r_bin_1      (in_r_bin_1),
        .in_vld          (in_vld),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .flush           (flush),
        .r_bin_0         (r_bin_0),
        .r_bin_1         (r_bin_1),
        .r_bin_vld       (r_bin_vld),
        .enable_V        (enable_V),
        .reset_rbins     (reset_rbins),
        .local_max_rbin  (local_max_rbin),
        .local_max_count (local_max_count),
        .local_max_vld   (local_max_vld),
        .res_rbin        (res_rbin),
        .res_count       (res_count),
        .res_nhits       (res_nhits),
        .res_found       (res_found),
        .res_overflow    (res_overflow),
        .res_vld         (res_vld),
        .res_ready       (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Histogram model: counts each distinct valid bin once per beat and emits
    // strictly increasing maxima, LSF_HIST_LAT cycles after r_bin_vld.
    int                        hcnt [0:127];
    int                        hmax;
    logic                      pv0, pv1;
    logic [RW-2:0]             pr0, pr1;
    logic [LSF_HIST_CNT_W-1:0] pc0, pc1;
    logic                      nv;
    logic [RW-2:0]             nr;
    logic [LSF_HIST_CNT_W-1:0] nc;
    logic [RW-1:0]             mbin [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || reset_rbins) begin
            for (int i = 0; i < 128; i++) hcnt[i] = 0;
            hmax = 0;
            pv0 <= 1'b0; pv1 <= 1'b0;
            pr0 <= '0;   pr1 <= '0;
            pc0 <= '0;   pc1 <= '0;
            local_max_vld   <= 1'b0;
            local_max_rbin  <= '0;
            local_max_count <= '0;
        end else begin
            local_max_vld   <= pv1;
            local_max_rbin  <= pr1;
            local_max_count <= pc1;
            pv1 <= pv0; pr1 <= pr0; pc1 <= pc0;
            nv = 1'b0; nr = '0; nc = '0;
            mbin[0] = r_bin_0;
            mbin[1] = r_bin_1;
            if (r_bin_vld) begin
                for (int k = 0; k < 2; k++) begin
                    if (!mbin[k][RW-1] && !(k == 1 && mbin[1] == mbin[0])) begin
                        hcnt[mbin[k][RW-2:0]]++;
                        if (hcnt[mbin[k][RW-2:0]] > hmax) begin
                            hmax = hcnt[mbin[k][RW-2:0]];
                            nv = 1'b1;
                            nr = mbin[k][RW-2:0];
                            nc = (hmax > 15) ? 4'd15 : LSF_HIST_CNT_W'(hmax);
                        end
                    end
                end
            end
            pv0 <= nv; pr0 <= nr; pc0 <= nc;
        end
    end

    int n_fwd = 0;
    int n_res = 0;
    int n_clr = 0;
    always @(posedge clk) begin
        if (r_bin_vld)   n_fwd++;
        if (res_vld)     n_res++;
        if (reset_rbins) n_clr++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [RW-1:0] b0, input logic [RW-1:0] b1, input logic last);
        in_vld     = 1'b1;
        in_r_bin_0 = b0;
        in_r_bin_1 = b1;
        in_last    = last;
        tick();
        in_vld     = 1'b0;
        in_last    = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (res_vld) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_res_vld"}, 32'(ok), 32'd1);
    endtask

    task automatic check_res(input string tag, input lsf_hist_res_t e);
        chk({tag, "_rbin"},     32'(res_rbin),     32'(e.rbin));
        chk({tag, "_count"},    32'(res_count),    32'(e.count));
        chk({tag, "_nhits"},    32'(res_nhits),    32'(e.nhits));
        chk({tag, "_found"},    32'(res_found),    32'(e.found));
        chk({tag, "_overflow"}, 32'(res_overflow), 32'(e.overflow));
    endtask

    task automatic consume(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_clr_pulse"}, 32'(reset_rbins), 32'd1);
        chk({tag, "_clr_resvld"}, 32'(res_vld), 32'd0);
        chk({tag, "_clr_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_clr_enV"}, 32'(enable_V), 32'd0);
        tick();
        chk({tag, "_idle_clr"}, 32'(reset_rbins), 32'd0);
        chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap_fwd, snap_res, snap_clr;

        rst_n = 1'b0; in_vld = 1'b0; in_last = 1'b0; flush = 1'b0; res_ready = 1'b0;
        in_r_bin_0 = '0; in_r_bin_1 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_enable_V", 32'(enable_V), 32'd1);
        chk("rst_r_bin_vld", 32'(r_bin_vld), 32'd0);
        chk("rst_res_vld", 32'(res_vld), 32'd0);
        chk("rst_reset_rbins", 32'(reset_rbins), 32'd0);
        chk("rst_res_nhits", 32'(res_nhits), 32'd0);

        // Peak event, result held back by res_ready for 10 cycles
        snap_fwd = n_fwd;
        send(8'd5, 8'd9, 1'b0);
        send(8'd5, 8'd12, 1'b0);
        send(8'd5, 8'h83, 1'b1);
        chk("ev1_drain_ready", 32'(in_ready), 32'd0);
        wait_res("ev1");
        check_res("ev1", '{rbin: 7'd5, count: 4'd3, nhits: 6'd3, found: 1'b1, overflow: 1'b0});
        chk("ev1_fwd", 32'(n_fwd - snap_fwd), 32'd3);
        chk("ev1_out_enV", 32'(enable_V), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_vld", 32'(res_vld), 32'd1);
            chk("stall_rbin", 32'(res_rbin), 32'd5);
            chk("stall_count", 32'(res_count), 32'd3);
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_clr", 32'(reset_rbins), 32'd0);
        end
        consume("ev1");

        // Only invalid bins
        send(8'h85, 8'h89, 1'b0);
        send(8'h80, 8'h81, 1'b1);
        wait_res("ev2");
        check_res("ev2", '{rbin: 7'd0, count: 4'd0, nhits: 6'd2, found: 1'b0, overflow: 1'b0});
        consume("ev2");

        // More beats than MAX_HITS
        snap_fwd = n_fwd;
        for (int i = 0; i < 6; i++) send(8'd1, 8'd2, (i == 5));
        wait_res("ev3");
        check_res("ev3", '{rbin: 7'd1, count: 4'd4, nhits: 6'd4, found: 1'b1, overflow: 1'b1});
        chk("ev3_fwd", 32'(n_fwd - snap_fwd), 32'd4);
        consume("ev3");

        // Flush two cycles into DRAIN
        snap_res = n_res;
        snap_clr = n_clr;
        send(8'd3, 8'd4, 1'b0);
        send(8'd3, 8'd4, 1'b1);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_clr", 32'(reset_rbins), 32'd1);
        chk("flush_resvld", 32'(res_vld), 32'd0);
        tick();
        chk("flush_idle_ready", 32'(in_ready), 32'd1);
        chk("flush_idle_clr", 32'(reset_rbins), 32'd0);
        repeat (8) tick();
        chk("flush_no_res", 32'(n_res - snap_res), 32'd0);
        chk("flush_one_clr", 32'(n_clr - snap_clr), 32'd1);

        send(8'd6, 8'h80, 1'b0);
        send(8'd6, 8'h80, 1'b0);
        send(8'd6, 8'h80, 1'b1);
        wait_res("ev5");
        check_res("ev5", '{rbin: 7'd6, count: 4'd3, nhits: 6'd3, found: 1'b1, overflow: 1'b0});
        consume("ev5");

        // Asynchronous reset in the middle of ACCUM
        send(8'd2, 8'd3, 1'b0);
        chk("pre_rst_fwd", 32'(r_bin_vld), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r_bin_vld", 32'(r_bin_vld), 32'd0);
        chk("arst_res_vld", 32'(res_vld), 32'd0);
        chk("arst_reset_rbins", 32'(reset_rbins), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_nhits", 32'(res_nhits), 32'd0);
        send(8'd7, 8'd7, 1'b1);
        wait_res("ev6");
        check_res("ev6", '{rbin: 7'd7, count: 4'd1, nhits: 6'd1, found: 1'b0, overflow: 1'b0});
        consume("ev6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
